// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned operands.
// Valid/ready on both sides, one operation in flight at a time.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   mula,
   input  logic [WIDTH-1:0]   mulb,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    ONE_C = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             vld_q, vld_d;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             hs;
   logic             zero_op;

   // Magnitudes stay unsigned in WIDTH bits, so the most-negative value maps
   // onto itself and is still multiplied correctly.
   assign mag_a = (signed_mode && mula[WIDTH-1]) ? (~mula + ONE_W) : mula;
   assign mag_b = (signed_mode && mulb[WIDTH-1]) ? (~mulb + ONE_W) : mulb;

   assign hs      = in_valid && (state_q == IDLE);
   assign zero_op = (mula == '0) || (mulb == '0);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      vld_d    = vld_q;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               a_d   = {{WIDTH{1'b0}}, mag_a};
               b_d   = mag_b;
               acc_d = '0;
               cnt_d = '0;
               neg_d = signed_mode && (mula[WIDTH-1] ^ mulb[WIDTH-1]);
               if (zero_op) begin
                  neg_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (b_q[0]) begin
               acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + ONE_C;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // First DONE cycle applies the sign and publishes the product.
            if (!vld_q) begin
               vld_d    = 1'b1;
               result_d = neg_q ? (~acc_q + ONE_P) : acc_q;
            end else if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         vld_q    <= vld_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = vld_q;
   assign result    = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8.
// Hand-computed products, latency, backpressure, reset abort, streaming.
module tb_seq_multiplier;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  mula;
   logic [7:0]  mulb;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        busy;

   int errors = 0;
   int checks = 0;

   seq_multiplier #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mula       (mula),
      .mulb       (mulb),
      .signed_mode(signed_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mul_op(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input int lat);
      int n;
      in_valid    = 1'b1;
      mula        = a;
      mulb        = b;
      signed_mode = s;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      mula        = ~a;
      mulb        = 8'h5A;
      signed_mode = ~s;
      chk({tag, "_busy"}, busy, 1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 20);
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, result, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, out_valid, 0);
      chk({tag, "_rdy"}, in_ready, 1);
      chk({tag, "_keep"}, result, exp);
   endtask

   logic [7:0]  bb_a [3];
   logic [7:0]  bb_b [3];
   logic [15:0] bb_p [3];

   initial begin
      int n;
      int k_in;
      int k_out;
      int cyc;
      int last_hs;
      logic prev_rdy;
      logic stray;

      reset       = 1'b1;
      in_valid    = 1'b0;
      mula        = '0;
      mulb        = '0;
      signed_mode = 1'b0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      reset = 1'b0;

      mul_op("u_3c_00", 8'h3C, 8'h00, 1'b0, 16'h0000, 1);
      mul_op("u_00_c3", 8'h00, 8'hC3, 1'b0, 16'h0000, 1);
      mul_op("u_3c_0d", 8'h3C, 8'h0D, 1'b0, 16'h030C, 9);
      mul_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
      mul_op("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 9);
      mul_op("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080, 9);
      mul_op("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000, 9);
      mul_op("s_03_fb", 8'h03, 8'hFB, 1'b1, 16'hFFF1, 9);
      mul_op("s_80_00", 8'h80, 8'h00, 1'b1, 16'h0000, 1);

      // Backpressure: 0x12 * 0x34 = 0x03A8 held for five cycles
      in_valid = 1'b1;
      mula     = 8'h12;
      mulb     = 8'h34;
      signed_mode = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_lat", n, 9);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            mula     = 8'h01;
            mulb     = 8'h01;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("bp_valid", out_valid, 1);
         chk("bp_res", result, 16'h03A8);
         chk("bp_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_drop", out_valid, 0);
      @(posedge clk);
      #1;
      chk("bp_noqueue", busy, 0);

      // Reset during the 4th CALC cycle
      in_valid = 1'b1;
      mula     = 8'h55;
      mulb     = 8'h66;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_res", result, 0);
      chk("abort_rdy", in_ready, 1);
      stray = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         stray = stray | out_valid;
      end
      chk("abort_stray", stray, 0);
      mul_op("u_03_05", 8'h03, 8'h05, 1'b0, 16'h000F, 9);

      // Streaming with out_ready tied high and in_valid held
      bb_a[0] = 8'h07; bb_b[0] = 8'h09; bb_p[0] = 16'h003F;
      bb_a[1] = 8'h10; bb_b[1] = 8'h10; bb_p[1] = 16'h0100;
      bb_a[2] = 8'hAB; bb_b[2] = 8'h02; bb_p[2] = 16'h0156;
      k_in      = 0;
      k_out     = 0;
      cyc       = 0;
      last_hs   = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      mula      = bb_a[0];
      mulb      = bb_b[0];
      signed_mode = 1'b0;
      prev_rdy  = in_ready;
      while (k_out < 3 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) begin
            chk("b2b_res", result, bb_p[k_out]);
            k_out++;
         end
         if (prev_rdy && in_valid) begin
            if (k_in > 0) chk("b2b_gap", cyc - last_hs, 11);
            last_hs = cyc;
            k_in++;
            if (k_in < 3) begin
               mula = bb_a[k_in];
               mulb = bb_b[k_in];
            end else begin
               in_valid = 1'b0;
            end
         end
         prev_rdy = in_ready;
      end
      chk("b2b_count", k_out, 3);
      chk("b2b_accepted", k_in, 3);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_idle", busy, 0);
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
